// File: rtl/traffic_light_param_ctrl.sv
// Two-phase intersection controller with pedestrian early exit and a flashing-yellow maintenance mode.
// All lamps come from registers loaded with the decode of the next state, so no input reaches an output combinationally.
module traffic_light_param_ctrl #(
  parameter int T_GREEN     = 8,
  parameter int T_MIN_GREEN = 4,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int FLASH_HALF  = 2,
  parameter int CNT_W       = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic PED_NS,
  input  logic PED_EW,
  input  logic FLASH,
  output logic RNS,
  output logic YNS,
  output logic GNS,
  output logic REW,
  output logic YEW,
  output logic GEW,
  output logic WALK_NS,
  output logic WALK_EW
);

  typedef enum logic [2:0] {
    ar_ns = 3'd0,
    ns_g  = 3'd1,
    ns_y  = 3'd2,
    ar_ew = 3'd3,
    ew_g  = 3'd4,
    ew_y  = 3'd5,
    fl    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] timer_r, timer_nxt_s;
  logic [CNT_W-1:0] fcnt_r, fcnt_nxt_s;
  logic             phase_r, phase_nxt_s;
  logic             pend_ns_r, pend_ns_nxt_s, pend_ew_r, pend_ew_nxt_s;
  logic             walk_ns_r, walk_ns_nxt_s, walk_ew_r, walk_ew_nxt_s;
  logic             enter_nsg_s, enter_ewg_s, enter_fl_s;
  logic             rns_r, yns_r, gns_r, rew_r, yew_r, gew_r;
  logic             rns_s, yns_s, gns_s, rew_s, yew_s, gew_s;

  // Next-state selection: timed sequence, early exit on cross request, flash diversion.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ar_ns: if (timer_r == ALLRED_LAST) state_nxt_s = FLASH ? fl : ns_g;
             else state_nxt_s = ar_ns;
      ns_g:  if (timer_r == GREEN_LAST || FLASH || (pend_ew_r && timer_r >= MIN_LAST)) state_nxt_s = ns_y;
             else state_nxt_s = ns_g;
      ns_y:  if (timer_r == YELLOW_LAST) state_nxt_s = ar_ew;
             else state_nxt_s = ns_y;
      ar_ew: if (timer_r == ALLRED_LAST) state_nxt_s = FLASH ? fl : ew_g;
             else state_nxt_s = ar_ew;
      ew_g:  if (timer_r == GREEN_LAST || FLASH || (pend_ns_r && timer_r >= MIN_LAST)) state_nxt_s = ew_y;
             else state_nxt_s = ew_g;
      ew_y:  if (timer_r == YELLOW_LAST) state_nxt_s = ar_ns;
             else state_nxt_s = ew_y;
      fl:    if (!FLASH) state_nxt_s = ar_ns;
             else state_nxt_s = fl;
      default: state_nxt_s = ar_ns;
    endcase
  end

  // Timers, flash phase, pending requests and walk grants for the next cycle.
  always_comb begin
    enter_nsg_s = (state_nxt_s == ns_g) && (state_r != ns_g);
    enter_ewg_s = (state_nxt_s == ew_g) && (state_r != ew_g);
    enter_fl_s  = (state_nxt_s == fl) && (state_r != fl);

    if (state_nxt_s != state_r) timer_nxt_s = {CNT_W{1'b0}};
    else if (timer_r == TIMER_MAX) timer_nxt_s = timer_r;
    else timer_nxt_s = timer_r + {{(CNT_W-1){1'b0}}, 1'b1};

    if (state_r == fl && !enter_fl_s) begin
      if (fcnt_r == HALF_LAST) begin
        fcnt_nxt_s  = {CNT_W{1'b0}};
        phase_nxt_s = ~phase_r;
      end else begin
        fcnt_nxt_s  = fcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        phase_nxt_s = phase_r;
      end
    end else begin
      fcnt_nxt_s  = {CNT_W{1'b0}};
      phase_nxt_s = 1'b1;
    end

    // A request arriving on the entry edge is dropped from pending but still granted a walk.
    pend_ns_nxt_s = enter_nsg_s ? 1'b0 : (pend_ns_r | PED_NS);
    pend_ew_nxt_s = enter_ewg_s ? 1'b0 : (pend_ew_r | PED_EW);

    if (state_nxt_s != ns_g) walk_ns_nxt_s = 1'b0;
    else if (enter_nsg_s) walk_ns_nxt_s = pend_ns_r | PED_NS;
    else walk_ns_nxt_s = walk_ns_r;

    if (state_nxt_s != ew_g) walk_ew_nxt_s = 1'b0;
    else if (enter_ewg_s) walk_ew_nxt_s = pend_ew_r | PED_EW;
    else walk_ew_nxt_s = walk_ew_r;
  end

  // Lamp decode of the state being entered.
  always_comb begin
    rns_s = 1'b0; yns_s = 1'b0; gns_s = 1'b0;
    rew_s = 1'b0; yew_s = 1'b0; gew_s = 1'b0;
    case (state_nxt_s)
      ar_ns, ar_ew: begin rns_s = 1'b1; rew_s = 1'b1; end
      ns_g:         begin gns_s = 1'b1; rew_s = 1'b1; end
      ns_y:         begin yns_s = 1'b1; rew_s = 1'b1; end
      ew_g:         begin gew_s = 1'b1; rns_s = 1'b1; end
      ew_y:         begin yew_s = 1'b1; rns_s = 1'b1; end
      fl:           begin yns_s = phase_nxt_s; yew_s = phase_nxt_s; end
      default:      begin rns_s = 1'b1; rew_s = 1'b1; end
    endcase
  end

  // State, flags and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ar_ns;
      timer_r   <= {CNT_W{1'b0}};
      fcnt_r    <= {CNT_W{1'b0}};
      phase_r   <= 1'b1;
      pend_ns_r <= 1'b0;
      pend_ew_r <= 1'b0;
      walk_ns_r <= 1'b0;
      walk_ew_r <= 1'b0;
      rns_r <= 1'b1; yns_r <= 1'b0; gns_r <= 1'b0;
      rew_r <= 1'b1; yew_r <= 1'b0; gew_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      fcnt_r    <= fcnt_nxt_s;
      phase_r   <= phase_nxt_s;
      pend_ns_r <= pend_ns_nxt_s;
      pend_ew_r <= pend_ew_nxt_s;
      walk_ns_r <= walk_ns_nxt_s;
      walk_ew_r <= walk_ew_nxt_s;
      rns_r <= rns_s; yns_r <= yns_s; gns_r <= gns_s;
      rew_r <= rew_s; yew_r <= yew_s; gew_r <= gew_s;
    end
  end

  assign RNS     = rns_r;
  assign YNS     = yns_r;
  assign GNS     = gns_r;
  assign REW     = rew_r;
  assign YEW     = yew_r;
  assign GEW     = gew_r;
  assign WALK_NS = walk_ns_r;
  assign WALK_EW = walk_ew_r;

endmodule

// File: tb/tb_traffic_light_param_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model of the intersection.
module tb_traffic_light_param_ctrl;

  localparam int TG = 8, TMIN = 4, TY = 3, TA = 2, FH = 2;
  localparam int I_GNS = 5, I_GEW = 2, I_WE = 0;

  logic CLK = 1'b0;
  logic RST = 1'b1, PED_NS = 1'b0, PED_EW = 1'b0, FLASH = 1'b0;
  logic RNS, YNS, GNS, REW, YEW, GEW, WALK_NS, WALK_EW;

  int checks = 0;
  int errors = 0;
  logic [7:0] obs;

  // Model: position in the six-step cycle (0 AR-before-NS, 1 NS green, 2 NS yellow,
  // 3 AR-before-EW, 4 EW green, 5 EW yellow), overlaid by a flash-mode flag.
  int m_pos, m_age, m_fc;
  bit m_fl, m_pn, m_pe, m_ph, m_wn, m_we;
  int ns_lamp[6] = '{0, 2, 1, 0, 0, 0};  // 0 red, 1 yellow, 2 green
  int ew_lamp[6] = '{0, 0, 0, 0, 2, 1};

  traffic_light_param_ctrl #(
    .T_GREEN(TG), .T_MIN_GREEN(TMIN), .T_YELLOW(TY), .T_ALLRED(TA), .FLASH_HALF(FH), .CNT_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .PED_NS(PED_NS), .PED_EW(PED_EW), .FLASH(FLASH),
    .RNS(RNS), .YNS(YNS), .GNS(GNS), .REW(REW), .YEW(YEW), .GEW(GEW),
    .WALK_NS(WALK_NS), .WALK_EW(WALK_EW)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] model_vec();
    logic [7:0] v;
    if (m_fl) v = {1'b0, m_ph, 1'b0, 1'b0, m_ph, 1'b0, 1'b0, 1'b0};
    else v = {ns_lamp[m_pos] == 0, ns_lamp[m_pos] == 1, ns_lamp[m_pos] == 2,
              ew_lamp[m_pos] == 0, ew_lamp[m_pos] == 1, ew_lamp[m_pos] == 2, m_wn, m_we};
    return v;
  endfunction

  task automatic model_step(input bit pn, input bit pe, input bit fl, input bit rs);
    int npos;
    bit nfl, leave, other, en_ns, en_ew;
    if (rs) begin
      m_pos = 0; m_age = 0; m_fc = 0; m_fl = 0;
      m_pn = 0; m_pe = 0; m_ph = 1; m_wn = 0; m_we = 0;
      return;
    end
    npos = m_pos; nfl = m_fl; leave = 0;
    if (m_fl) begin
      if (!fl) begin leave = 1; nfl = 0; npos = 0; end
      else begin
        m_fc++;
        if (m_fc == FH) begin m_ph = !m_ph; m_fc = 0; end
      end
    end else if (m_pos == 1 || m_pos == 4) begin
      other = (m_pos == 1) ? m_pe : m_pn;
      if (m_age == TG - 1 || fl || (other && m_age >= TMIN - 1)) begin leave = 1; npos = m_pos + 1; end
    end else if (m_pos == 2 || m_pos == 5) begin
      if (m_age == TY - 1) begin leave = 1; npos = (m_pos + 1) % 6; end
    end else begin
      if (m_age == TA - 1) begin
        leave = 1;
        if (fl) begin nfl = 1; m_ph = 1; m_fc = 0; end
        else npos = m_pos + 1;
      end
    end
    en_ns = leave && !nfl && npos == 1;
    en_ew = leave && !nfl && npos == 4;
    if (leave) begin
      m_wn = en_ns ? (m_pn | pn) : 1'b0;
      m_we = en_ew ? (m_pe | pe) : 1'b0;
    end
    m_pn = en_ns ? 1'b0 : (m_pn | pn);
    m_pe = en_ew ? 1'b0 : (m_pe | pe);
    m_age = leave ? 0 : m_age + 1;
    m_pos = npos;
    m_fl = nfl;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit pn, input bit pe, input bit fl, input bit rs);
    PED_NS = pn; PED_EW = pe; FLASH = fl; RST = rs;
    @(posedge CLK);
    model_step(pn, pe, fl, rs);
    @(negedge CLK);
    obs = {RNS, YNS, GNS, REW, YEW, GEW, WALK_NS, WALK_EW};
    check("lamps_vs_model", obs, model_vec());
    check("green_overlap", {7'd0, GNS & GEW}, 8'd0);
  endtask

  task automatic wait_lamp(input int idx, input bit fl);
    int n = 0;
    while (obs[idx] !== 1'b1 && n < 60) begin cyc(1'b0, 1'b0, fl, 1'b0); n++; end
    check("wait_lamp_timeout", {7'd0, obs[idx]}, 8'd1);
  endtask

  task automatic count_lamp(input int idx, output int n);
    n = 0;
    while (obs[idx] === 1'b1 && n < 60) begin n++; cyc(1'b0, 1'b0, 1'b0, 1'b0); end
  endtask

  initial begin
    int n;
    bit fl_lvl;
    obs = 8'd0;
    @(negedge CLK);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_lamps", obs, 8'b1001_0000);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("reset_priority", obs, 8'b1001_0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_allred", obs, 8'b1001_0000);

    // Idle cycle: full greens.
    wait_lamp(I_GNS, 1'b0);
    count_lamp(I_GNS, n);
    check("idle_ns_green_len", 8'(n), 8'd8);
    wait_lamp(I_GEW, 1'b0);
    count_lamp(I_GEW, n);
    check("idle_ew_green_len", 8'(n), 8'd8);

    // EW request at NS green timer 1: early exit after 4 cycles, walk for the full EW green.
    wait_lamp(I_GNS, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    count_lamp(I_GNS, n);
    check("early_exit_t1_len", 8'(n + 2), 8'd4);
    wait_lamp(I_GEW, 1'b0);
    count_lamp(I_WE, n);
    check("walk_ew_len", 8'(n), 8'd8);

    // EW request at NS green timer 5: green lasts 7 cycles.
    wait_lamp(I_GNS, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    count_lamp(I_GNS, n);
    check("early_exit_t5_len", 8'(n + 6), 8'd7);

    // Flash requested at NS green entry: yellow, all-red, then flashing yellow.
    wait_lamp(I_GNS, 1'b0);
    repeat (6) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("flash_first", obs, 8'b0100_1000);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("flash_dark", obs, 8'b0000_0000);
    repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("flash_exit_green", obs, 8'b0011_0010);

    // Reset in EW green with an NS request pending.
    wait_lamp(I_GEW, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_mid_ew", obs, 8'b1001_0000);

    // Randomized traffic.
    fl_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) fl_lvl = !fl_lvl;
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, fl_lvl,
          $urandom_range(0, 599) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_param_ctrl.md
TRAFFIC_LIGHT_PARAM_CTRL -- requirements
Module: traffic_light_param_ctrl

Interface
REQ-001 Parameter T_GREEN, default 8: full green duration in clock cycles (>=1).
REQ-002 Parameter T_MIN_GREEN, default 4: minimum green before pedestrian early exit (1..T_GREEN).
REQ-003 Parameter T_YELLOW, default 3: yellow duration in cycles (>=1).
REQ-004 Parameter T_ALLRED, default 2: all-red clearance duration in cycles (>=1).
REQ-005 Parameter FLASH_HALF, default 2: flash half-period in cycles (>=1).
REQ-006 Parameter CNT_W, default 8: state-timer width; SHALL hold max(all durations)-1.
REQ-007 CLK  input  1  single clock, all state changes on rising edge.
REQ-008 RST  input  1  synchronous reset, active-high.
REQ-009 PED_NS  input  1  NS pedestrian request, level or single-cycle pulse.
REQ-010 PED_EW  input  1  EW pedestrian request, level or single-cycle pulse.
REQ-011 FLASH  input  1  flashing-yellow maintenance mode request (level).
REQ-012 RNS, YNS, GNS  output  1 each  north-south red/yellow/green lamps.
REQ-013 REW, YEW, GEW  output  1 each  east-west red/yellow/green lamps.
REQ-014 WALK_NS, WALK_EW  output  1 each  pedestrian walk lamps.

Function
REQ-015 States SHALL be: AR_NS (all red, NS next), NS_G, NS_Y, AR_EW (all red, EW next), EW_G, EW_Y, FL (flash).
REQ-016 Outputs SHALL be Moore-decoded from registered state/flags; no input-to-output combinational path.
REQ-017 Lamps: AR_* -> RNS=REW=1; NS_G -> GNS=REW=1; NS_Y -> YNS=REW=1; EW_G -> GEW=RNS=1; EW_Y -> YEW=RNS=1; FL -> YNS=YEW=flash phase, all others 0; all unlisted lamps 0.
REQ-018 A timer SHALL read 0 in the first cycle of every state and increment each cycle; no wrap (bounded by REQ-006).
REQ-019 Normal sequence: AR_NS(T_ALLRED) -> NS_G(T_GREEN) -> NS_Y(T_YELLOW) -> AR_EW(T_ALLRED) -> EW_G(T_GREEN) -> EW_Y(T_YELLOW) -> AR_NS; state leaves after the cycle where timer == duration-1.
REQ-020 Pending flags pend_ns/pend_ew SHALL set on the edge after PED_NS/PED_EW is sampled high; a flag clears on the edge entering its own green state.
REQ-021 Set and clear on the same edge: clear wins (request serviced by the green being entered).
REQ-022 WALK_NS SHALL be 1 for all of NS_G iff pend_ns was 1 when NS_G was entered; likewise WALK_EW for EW_G; 0 in all other states.
REQ-023 Early exit: in NS_G, if pend_ew=1 and timer >= T_MIN_GREEN-1, next state is NS_Y; symmetric for EW_G with pend_ns.
REQ-024 FLASH=1 in a G state: next state is that direction's Y; Y and AR states run to completion; at AR end with FLASH=1 next state is FL instead of green.
REQ-025 In FL: flash phase starts 1, toggles every FLASH_HALF cycles; WALK_* = 0; pending flags keep accumulating.
REQ-026 FLASH=0 sampled in FL: next state AR_NS (full T_ALLRED), then normal sequence.
REQ-027 GNS and GEW SHALL never be 1 simultaneously; every green is preceded by >= T_ALLRED all-red cycles.

Reset
REQ-028 RST=1 sampled SHALL force state AR_NS, timer 0, pend_ns=pend_ew=0, flash phase 1, regardless of current state.
REQ-029 During and on the cycle after reset: RNS=REW=1, all other outputs 0.
REQ-030 Reset SHALL take priority over FLASH and PED inputs on the same edge.

Verification (defaults)
REQ-031 Release RST, no requests -> AR_NS 2, NS_G 8, NS_Y 3, AR_EW 2, EW_G 8, EW_Y 3 cycles; period 26; GNS/GEW never overlap.
REQ-032 PED_EW pulse at NS_G timer=1 -> NS_G lasts 4 cycles; EW_G has WALK_EW=1 for all 8 cycles; pend_ew 0 after entry.
REQ-033 PED_EW pulse at NS_G timer=5 -> NS_G lasts 7 cycles, then NS_Y 3.
REQ-034 PED_NS held high through EW_G entry of NS_G -> WALK_NS=1 whole NS_G; pend_ns re-sets next cycle if still high, serviced next NS_G.
REQ-035 FLASH=1 during NS_G -> NS_Y 3, AR_EW 2, then FL with YNS=YEW pattern 1,1,0,0,...; FLASH=0 -> AR_NS 2 cycles then NS_G.
REQ-036 RST=1 mid EW_G with pend_ns=1 -> next cycle AR_NS, RNS=REW=1, WALK_*=0, pend flags 0.
